// File: rtl/store_drain.sv
// store_drain: retires ROB-committed stores from the store buffer head
// into data memory over a req/ack handshake, one store in flight at a
// time, with a timeout-driven retry of stalled requests.
module store_drain #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ROB_ADDR_WIDTH = 4,
    parameter int COMMIT_DEPTH   = 8,
    parameter int TIMEOUT        = 15,
    localparam int PEND_WIDTH    = $clog2(COMMIT_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sb_valid,
    input  logic                      sb_ready,
    input  logic [ROB_ADDR_WIDTH-1:0] sb_rob_addr,
    input  logic [ADDR_WIDTH-1:0]     sb_addr,
    input  logic [DATA_WIDTH-1:0]     sb_data,
    output logic                      sb_pop,
    input  logic                      commit_valid,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      mem_ack,
    output logic [PEND_WIDTH-1:0]     pending,
    output logic                      busy,
    output logic                      overflow,
    output logic [7:0]                retries
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RETRY
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [TIMER_WIDTH-1:0]    timer;
    logic [ROB_ADDR_WIDTH-1:0] inflight_rob;
    logic                      start;
    logic                      timed_out;
    logic                      commit_at_full;

    // A committed store can be issued only once the head has address and data.
    assign start          = (pending != '0) && sb_valid && sb_ready;
    assign timed_out      = (timer == TIMER_WIDTH'(TIMEOUT - 1));
    assign commit_at_full = commit_valid && !sb_pop &&
                            (pending == PEND_WIDTH'(COMMIT_DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: issue, wait for ack, back off one cycle on timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    next_state = IDLE;
                end else if (timed_out) begin
                    next_state = RETRY;
                end
            end
            RETRY: begin
                next_state = REQ;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; the pop fires in the same cycle as the ack.
    always_comb begin
        sb_pop = (state == REQ) && mem_ack;
        busy   = (state != IDLE);
    end

    // Registered request plus the address/data/ROB tag latched at issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            inflight_rob <= '0;
        end else begin
            mem_req <= (next_state == REQ);
            if (state == IDLE && start) begin
                mem_addr     <= sb_addr;
                mem_data     <= sb_data;
                inflight_rob <= sb_rob_addr;
            end
        end
    end

    // Cycles spent in the current request attempt; cleared outside REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == REQ && !mem_ack && !timed_out) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // Saturating count of timeout retries.
    always_ff @(posedge clk) begin
        if (rst) begin
            retries <= '0;
        end else if (state == REQ && !mem_ack && timed_out && retries != 8'hFF) begin
            retries <= retries + 8'd1;
        end
    end

    // Committed-but-unwritten count; a commit into a full counter is lost and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (commit_at_full) begin
            overflow <= 1'b1;
        end else if (commit_valid && !sb_pop) begin
            pending <= pending + 1'b1;
        end else if (!commit_valid && sb_pop) begin
            pending <= pending - 1'b1;
        end
    end

    // The store being retired must still be the one at the buffer head.
    property p_pop_same_head;
        @(posedge clk) disable iff (rst) sb_pop |-> (sb_rob_addr == inflight_rob);
    endproperty
    assert property (p_pop_same_head);

endmodule

// File: tb/tb_store_drain.sv
// tb_store_drain: directed scenarios plus randomized traffic against a
// behavioural model of the drain (queue-based store buffer, periodic
// request/backoff pattern per in-flight store).
module tb_store_drain;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CD = 8;
    localparam int TO = 15;
    localparam int PW = $clog2(CD + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          sb_valid;
    logic          sb_ready;
    logic [RW-1:0] sb_rob_addr;
    logic [AW-1:0] sb_addr;
    logic [DW-1:0] sb_data;
    logic          sb_pop;
    logic          commit_valid;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic [PW-1:0] pending;
    logic          busy;
    logic          overflow;
    logic [7:0]    retries;

    always #5 clk = ~clk;

    store_drain #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROB_ADDR_WIDTH(RW),
        .COMMIT_DEPTH(CD), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .sb_valid(sb_valid), .sb_ready(sb_ready), .sb_rob_addr(sb_rob_addr),
        .sb_addr(sb_addr), .sb_data(sb_data), .sb_pop(sb_pop),
        .commit_valid(commit_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .pending(pending), .busy(busy), .overflow(overflow), .retries(retries)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
    } entry_t;

    entry_t        sbq[$];
    bit            refill;
    logic [RW-1:0] nextRob;

    int errors;
    int checks;

    // Model state: an in-flight store requests for TO cycles, then backs off one.
    int            mPending;
    bit            mOverflow;
    int            mRetries;
    bit            mInFlight;
    int            mAge;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;

    function automatic bit expReq();
        return mInFlight && ((mAge % (TO + 1)) < TO);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPending  = 0;
        mOverflow = 0;
        mRetries  = 0;
        mInFlight = 0;
        mAge      = 0;
        mAddr     = '0;
        mData     = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        bit pop;
        int oldP;
        pop  = expReq() && mem_ack;
        oldP = mPending;
        if (rst) begin
            modelReset();
        end else begin
            if (commit_valid && !pop && mPending == CD) begin
                mOverflow = 1;
            end else begin
                mPending = mPending + (commit_valid ? 1 : 0) - (pop ? 1 : 0);
            end
            if (mInFlight) begin
                if (pop) begin
                    mInFlight = 0;
                end else begin
                    mAge++;
                    if ((mAge % (TO + 1)) == TO && mRetries < 255) mRetries++;
                end
            end else if (oldP > 0 && sb_valid && sb_ready) begin
                mInFlight = 1;
                mAge      = 0;
                mAddr     = sb_addr;
                mData     = sb_data;
            end
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic checkOutput();
        checkVal("mem_req", 32'(mem_req), 32'(expReq()));
        checkVal("sb_pop", 32'(sb_pop), 32'(expReq() && mem_ack));
        checkVal("pending", 32'(pending), mPending);
        checkVal("busy", 32'(busy), 32'(mInFlight));
        checkVal("overflow", 32'(overflow), 32'(mOverflow));
        checkVal("retries", 32'(retries), mRetries);
        if (expReq()) begin
            checkVal("mem_addr", 32'(mem_addr), 32'(mAddr));
            checkVal("mem_data", 32'(mem_data), 32'(mData));
        end
    endtask

    task automatic pushEntry(input logic [AW-1:0] a, input logic [DW-1:0] d);
        entry_t e;
        e.a = a;
        e.d = d;
        e.r = nextRob;
        nextRob = nextRob + 4'd1;
        sbq.push_back(e);
    endtask

    // Drive one cycle's inputs, then compare outputs once they have settled.
    task automatic applyStimulus(input bit r, input bit c, input bit rdy, input bit ack, input bit vld);
        rst          = r;
        commit_valid = c;
        sb_ready     = rdy;
        mem_ack      = ack;
        if (sbq.size() > 0) begin
            sb_valid    = vld;
            sb_addr     = sbq[0].a;
            sb_data     = sbq[0].d;
            sb_rob_addr = sbq[0].r;
        end else begin
            sb_valid    = 1'b0;
            sb_addr     = '0;
            sb_data     = '0;
            sb_rob_addr = '0;
        end
        #1;
        checkOutput();
    endtask

    // Clock edge: model and store buffer both react to this cycle's inputs.
    task automatic stepClock();
        bit popNow;
        popNow = (sb_pop === 1'b1);
        modelStep();
        @(posedge clk);
        #1;
        if (popNow && sbq.size() > 0) void'(sbq.pop_front());
        if (refill) begin
            while (sbq.size() < 4) pushEntry(AW'($urandom), DW'($urandom));
        end
    endtask

    initial begin
        int pops;
        int ackPct;
        errors  = 0;
        checks  = 0;
        refill  = 0;
        nextRob = '0;
        rst = 1'b1; commit_valid = 1'b0; sb_valid = 1'b0; sb_ready = 1'b0;
        mem_ack = 1'b0; sb_addr = '0; sb_data = '0; sb_rob_addr = '0;
        @(posedge clk);
        #1;
        modelReset();

        // Reset state.
        applyStimulus(1, 0, 0, 0, 1);
        checkVal("rst_mem_req", 32'(mem_req), 32'd0);
        checkVal("rst_pending", 32'(pending), 32'd0);
        checkVal("rst_retries", 32'(retries), 32'd0);
        checkVal("rst_mem_addr", 32'(mem_addr), 32'd0);
        stepClock();

        // Single store with immediate ack.
        pushEntry(16'h0040, 16'hBEEF);
        applyStimulus(0, 1, 1, 0, 1);
        checkVal("single_pend0", 32'(pending), 32'd0);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("single_pend1", 32'(pending), 32'd1);
        checkVal("single_noreq", 32'(mem_req), 32'd0);
        stepClock();
        applyStimulus(0, 0, 1, 1, 1);
        checkVal("single_req", 32'(mem_req), 32'd1);
        checkVal("single_addr", 32'(mem_addr), 32'h0040);
        checkVal("single_data", 32'(mem_data), 32'hBEEF);
        checkVal("single_pop", 32'(sb_pop), 32'd1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("single_pend_end", 32'(pending), 32'd0);
        checkVal("single_busy_end", 32'(busy), 32'd0);
        stepClock();

        // Head not ready: no request until sb_ready is sampled high.
        pushEntry(16'h0100, 16'hA5A5);
        applyStimulus(0, 1, 0, 0, 1);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkVal("notready_noreq", 32'(mem_req), 32'd0);
            stepClock();
        end
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("notready_edge", 32'(mem_req), 32'd0);
        stepClock();
        applyStimulus(0, 0, 1, 1, 1);
        checkVal("notready_req", 32'(mem_req), 32'd1);
        checkVal("notready_addr", 32'(mem_addr), 32'h0100);
        stepClock();

        // Timeout: 15 request cycles, one gap, re-request, ack on 3rd retry cycle.
        pushEntry(16'h1234, 16'h5678);
        applyStimulus(0, 1, 1, 0, 1);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1);
        stepClock();
        for (int i = 0; i < TO; i++) begin
            applyStimulus(0, 0, 1, 0, 1);
            checkVal("timeout_req_high", 32'(mem_req), 32'd1);
            stepClock();
        end
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("timeout_gap", 32'(mem_req), 32'd0);
        checkVal("timeout_retries", 32'(retries), 32'd1);
        stepClock();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 0, 1);
            checkVal("retry_req", 32'(mem_req), 32'd1);
            checkVal("retry_addr", 32'(mem_addr), 32'h1234);
            stepClock();
        end
        applyStimulus(0, 0, 1, 1, 1);
        checkVal("retry_pop", 32'(sb_pop), 32'd1);
        checkVal("retry_data", 32'(mem_data), 32'h5678);
        stepClock();
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("retry_count_held", 32'(retries), 32'd1);
        checkVal("retry_idle", 32'(busy), 32'd0);
        stepClock();

        // Commit in the same cycle as a drain, then back-to-back drains.
        for (int i = 0; i < 3; i++) pushEntry(AW'(16'h2000 + i), DW'(16'h7000 + i));
        applyStimulus(0, 1, 0, 0, 1);
        stepClock();
        applyStimulus(0, 1, 0, 0, 1);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("simul_pend2", 32'(pending), 32'd2);
        stepClock();
        pops = 0;
        applyStimulus(0, 1, 1, 1, 1);
        if (sb_pop === 1'b1) pops++;
        stepClock();
        applyStimulus(0, 0, 1, 1, 1);
        checkVal("simul_pend_hold", 32'(pending), 32'd2);
        if (sb_pop === 1'b1) pops++;
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 1, 1);
            if (sb_pop === 1'b1) pops++;
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("simul_pops", pops, 32'd3);
        checkVal("simul_pend_end", 32'(pending), 32'd0);
        stepClock();

        // Overflow: nine commits with nothing draining.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 0, 0, 1);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("ovf_pend_sat", 32'(pending), 32'd8);
        checkVal("ovf_flag", 32'(overflow), 32'd1);
        stepClock();
        for (int i = 0; i < 8; i++) pushEntry(AW'(16'h4000 + i), DW'(16'h9000 + i));
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 1, 1);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("ovf_drained", 32'(pending), 32'd0);
        checkVal("ovf_sticky", 32'(overflow), 32'd1);
        stepClock();

        // Reset while a request is outstanding.
        pushEntry(16'h3000, 16'hC0DE);
        applyStimulus(0, 1, 1, 0, 1);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1);
        stepClock();
        applyStimulus(0, 0, 1, 0, 1);
        checkVal("midrst_req", 32'(mem_req), 32'd1);
        stepClock();
        applyStimulus(1, 0, 1, 0, 1);
        checkVal("midrst_nopop", 32'(sb_pop), 32'd0);
        stepClock();
        applyStimulus(0, 0, 0, 0, 1);
        checkVal("midrst_req_low", 32'(mem_req), 32'd0);
        checkVal("midrst_pend", 32'(pending), 32'd0);
        checkVal("midrst_ovf", 32'(overflow), 32'd0);
        stepClock();

        // Randomized traffic with varying memory responsiveness.
        refill = 1;
        ackPct = 50;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            if (i % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0: ackPct = 3;
                    1: ackPct = 25;
                    2: ackPct = 60;
                    default: ackPct = 95;
                endcase
            end
            r = ($urandom_range(0, 399) == 0);
            applyStimulus(r,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) != 0,
                          !r && ($urandom_range(0, 99) < ackPct),
                          $urandom_range(0, 7) != 0);
            stepClock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_drain.md
Name: store_drain

Overview:
- Sits directly downstream of the in-order store buffer.
- Retires committed stores from the buffer head into data memory through a req/ack handshake, and pops the buffer once each write is accepted.
- Tracks how many stores the ROB has committed but not yet written, so only architecturally committed stores ever reach memory.
- One store in flight at a time; program order is preserved.

Parameters:
ADDR_WIDTH, 16, data memory address width
DATA_WIDTH, 16, store data width
ROB_ADDR_WIDTH, 4, width of ROB index carried with each store
COMMIT_DEPTH, 8, max committed-but-undrained stores; sizes the commit counter as clog2(COMMIT_DEPTH+1) bits
TIMEOUT, 15, cycles mem_req may stay high without mem_ack before a retry

Ports:
clk  in  1  clock; all state changes on posedge
rst  in  1  synchronous, active-high reset
sb_valid  in  1  store buffer head holds a valid entry
sb_ready  in  1  head entry has computed address and data
sb_rob_addr  in  ROB_ADDR_WIDTH  ROB index of head entry
sb_addr  in  ADDR_WIDTH  head store address
sb_data  in  DATA_WIDTH  head store data
sb_pop  out  1  combinational one-cycle pulse; store buffer advances head at this edge
commit_valid  in  1  ROB retires one store this cycle
mem_req  out  1  write request to data memory
mem_addr  out  ADDR_WIDTH  latched write address
mem_data  out  DATA_WIDTH  latched write data
mem_ack  in  1  memory accepted the write (sampled only while mem_req=1)
pending  out  clog2(COMMIT_DEPTH+1)  committed stores not yet written
busy  out  1  state != IDLE
overflow  out  1  sticky error: commit_valid while pending==COMMIT_DEPTH with no same-cycle drain
retries  out  8  saturating count of timeout retries since reset

Behaviour:
- Reset: rst=1 at a posedge forces state=IDLE, pending=0, mem_req=0, mem_addr=0, mem_data=0, overflow=0, retries=0, timer=0.
- Reset mid-transaction: mem_req drops the cycle after the reset edge; the in-flight store is abandoned with no sb_pop.
- States: IDLE, REQ, RETRY.
- IDLE → REQ:
  - Transition when pending>0 & sb_valid & sb_ready.
  - Latch sb_addr and sb_data into mem_addr and mem_data; timer=0.
  - mem_req is registered, so it is high in the first REQ cycle.
- IDLE otherwise: hold.
- REQ:
  - mem_req=1; mem_addr and mem_data stay stable until the ack.
  - If mem_ack=1: sb_pop=1 combinationally this cycle and next state=IDLE.
  - Else if timer==TIMEOUT-1: next state=RETRY and retries+=1, saturating at 255.
  - Else timer+=1.
- RETRY: mem_req=0 for exactly one cycle, then REQ with timer=0 and the same latched addr/data.
- Throughput: one store per 2 cycles minimum (IDLE→REQ, ack in the first REQ cycle, back to IDLE).
- sb_pop is asserted only in REQ with mem_ack=1; never in IDLE or RETRY.
- pending update at each edge: +commit_valid −sb_pop.
  - Simultaneous commit and drain leaves pending unchanged.
  - pending==0 with no commit stays 0; no underflow is possible because drain requires pending>0.
  - pending==COMMIT_DEPTH with commit_valid and no sb_pop: pending holds and overflow sets, sticky until rst.
- Commit latency: commit_valid at edge t makes pending=1 after t; the IDLE→REQ decision is taken at edge t+1, and mem_req is high in the cycle after t+1.
- sb_valid=1 & sb_ready=0 with pending>0: wait in IDLE; no request is issued.
- sb_rob_addr is not used for control; it is carried for debug and assertion only.
- mem_ack while mem_req=0: ignored.

Test Plan:
- Single store: rst, one commit_valid pulse, sb head addr=0x0040 data=0xBEEF ready, mem_ack on the 1st REQ cycle -> mem_req high for one cycle with 0x0040/0xBEEF, sb_pop one pulse, pending 0→1→0, busy back to 0.
- Not-ready head: pending=1, sb_ready=0 for 5 cycles then 1 -> no mem_req during the wait; mem_req rises the cycle after sb_ready samples 1.
- Timeout retry: TIMEOUT=15, mem_ack held low -> mem_req high 15 cycles, low 1 cycle, high again with the same addr/data, retries=1; ack on cycle 3 of the retry -> single sb_pop, retries stays 1.
- Simultaneous commit and drain: pending=2, commit_valid in the same cycle as the ack -> pending stays 2, then drains 3 stores back-to-back at 2 cycles each with ack immediate.
- Overflow: 9 commits with mem_ack=0 and sb_ready=0, COMMIT_DEPTH=8 -> pending saturates at 8, overflow=1, stays 1 after draining to 0.
- Reset mid-REQ: assert rst while mem_req=1 -> mem_req=0, pending=0, no sb_pop, overflow=0 the next cycle.
